// File: rtl/gated_pulse_counter.sv
// gated_pulse_counter
//   Counts pulses from the selected measurement source over alternating gate
//   phases. gate high is the PLUS phase and gate low is the MINUS phase. One
//   24-bit measurement word is produced per full gate period and written to
//   the measurement FIFO.
//
// Ports
//   clk_12mhz   system clock
//   rst_sync    synchronous active-high reset
//   cnt_in      asynchronous pulse stream; each rising edge counts once
//   cnt_en      asynchronous count enable, synchronised like cnt_in
//   gate        asynchronous phase reference (1 = PLUS, 0 = MINUS)
//   count_mode  0 = raw PLUS count, 1 = signed PLUS-MINUS difference
//   fifo_full   FIFO Full flag
//   count_word  measurement word; holds its value until the next write
//   wr_en       one-cycle FIFO write strobe
//   overflow    sticky: an accumulator saturated or a word was dropped
//   drop_cnt    saturating count of words discarded because fifo_full=1
//   busy        high while aligned and counting
//   state_dbg   current FSM state (ALIGN=0, PLUS=1, MINUS=2)
//
// Handshake: wr_en/count_word form a valid-only push into the FIFO. A word is
// pushed (wr_en=1 for exactly one cycle) only when fifo_full was 0 in the
// cycle the period ended; otherwise the word is discarded and counted in
// drop_cnt. There is no stall path back into the counter.
module gated_pulse_counter #(
  parameter int CNT_W       = 23,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W      = 8,
  parameter int STUCK_W     = 17
) (
  input  logic              clk_12mhz,
  input  logic              rst_sync,
  input  logic              cnt_in,
  input  logic              cnt_en,
  input  logic              gate,
  input  logic              count_mode,
  input  logic              fifo_full,
  output logic [23:0]       count_word,
  output logic              wr_en,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    PLUS  = 2'd1,
    MINUS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] cin_sr, en_sr, gate_sr;
  logic                   cin_prev, gate_prev;
  logic                   cin_s, en_s, gate_s;
  logic                   pulse, g_rise, g_fall;

  logic [CNT_W-1:0]   acc_p, acc_m, acc_p_n, acc_m_n;
  logic [CNT_W:0]     diff;
  logic [23:0]        word_n;
  logic               sat_p;
  logic               emit, stuck_clr, timeout;
  logic [STUCK_W-1:0] stuck_cnt;

  assign cin_s  = cin_sr[SYNC_STAGES-1];
  assign en_s   = en_sr[SYNC_STAGES-1];
  assign gate_s = gate_sr[SYNC_STAGES-1];

  assign pulse  = cin_s & ~cin_prev & en_s;
  assign g_rise = gate_s & ~gate_prev;
  assign g_fall = ~gate_s & gate_prev;

  assign timeout = (stuck_cnt == '1);

  // Accumulators stop at full scale, so "saturated during the period" is
  // simply "sitting at full scale now".
  assign sat_p = (acc_p == ACC_MAX);
  assign diff  = {1'b0, acc_p} - {1'b0, acc_m};
  assign word_n = count_mode ? 24'($signed(diff)) : {sat_p, 23'(acc_p)};

  assign busy      = (state != ALIGN);
  assign state_dbg = state;

  // Synchronisers, edge-history flops and the stuck-gate timer.
  always_ff @(posedge clk_12mhz) begin
    if (rst_sync) begin
      cin_sr    <= '0;
      en_sr     <= '0;
      gate_sr   <= '0;
      cin_prev  <= 1'b0;
      gate_prev <= 1'b0;
      stuck_cnt <= '0;
    end else begin
      cin_sr    <= {cin_sr[SYNC_STAGES-2:0], cnt_in};
      en_sr     <= {en_sr[SYNC_STAGES-2:0], cnt_en};
      gate_sr   <= {gate_sr[SYNC_STAGES-2:0], gate};
      cin_prev  <= cin_s;
      gate_prev <= gate_s;
      if (stuck_clr || g_rise || g_fall) stuck_cnt <= '0;
      else                               stuck_cnt <= stuck_cnt + 1'b1;
    end
  end

  // State register, accumulators and FIFO-side outputs.
  always_ff @(posedge clk_12mhz) begin
    if (rst_sync) begin
      state      <= ALIGN;
      acc_p      <= '0;
      acc_m      <= '0;
      count_word <= '0;
      wr_en      <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state <= state_n;
      acc_p <= acc_p_n;
      acc_m <= acc_m_n;
      wr_en <= emit & ~fifo_full;
      if (emit && !fifo_full) count_word <= word_n;
      if (emit && fifo_full && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if ((acc_p_n == ACC_MAX) || (acc_m_n == ACC_MAX) || (emit && fifo_full))
        overflow <= 1'b1;
    end
  end

  // Next-state logic. A pulse that lands in the same cycle as a gate edge is
  // always credited to the phase that edge starts.
  always_comb begin
    state_n   = state;
    acc_p_n   = acc_p;
    acc_m_n   = acc_m;
    emit      = 1'b0;
    stuck_clr = 1'b0;
    case (state)
      ALIGN: begin
        acc_p_n   = '0;
        acc_m_n   = '0;
        stuck_clr = 1'b1;
        if (g_rise) begin
          state_n = PLUS;
          acc_p_n = CNT_W'(pulse);
        end
      end
      PLUS: begin
        if (g_fall) begin
          state_n = MINUS;
          acc_m_n = CNT_W'(pulse);
        end else if (timeout) begin
          state_n = ALIGN;
          acc_p_n = '0;
          acc_m_n = '0;
        end else if (pulse && acc_p != ACC_MAX) begin
          acc_p_n = acc_p + CNT_W'(1);
        end
      end
      MINUS: begin
        if (g_rise) begin
          state_n = PLUS;
          emit    = 1'b1;
          acc_p_n = CNT_W'(pulse);
          acc_m_n = '0;
        end else if (timeout) begin
          state_n = ALIGN;
          acc_p_n = '0;
          acc_m_n = '0;
        end else if (pulse && acc_m != ACC_MAX) begin
          acc_m_n = acc_m + CNT_W'(1);
        end
      end
      default: begin
        state_n = ALIGN;
        acc_p_n = '0;
        acc_m_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gated_pulse_counter.sv
// Bench for gated_pulse_counter: a full-width instance (a) and a 4-bit
// accumulator instance (b) for the saturation/stuck-gate scenario. sel routes
// the shared pulse/gate drivers to one instance; the other sees idle inputs.
module tb_gated_pulse_counter;

  // clock / reset
  logic clk_12mhz = 1'b0;
  always #5 clk_12mhz = ~clk_12mhz;

  logic rst_sync   = 1'b1;
  logic cnt_d      = 1'b0;
  logic en_d       = 1'b1;
  logic gate_d     = 1'b0;
  logic count_mode = 1'b0;
  logic fifo_full  = 1'b0;
  logic sel        = 1'b0;

  logic [23:0] word_a, word_b;
  logic        wr_a, wr_b, ovf_a, ovf_b, busy_a, busy_b;
  logic [7:0]  drop_a, drop_b;
  logic [1:0]  st_a, st_b;

  int total = 0;
  int bad   = 0;

  logic [23:0] got_a_q[$];
  logic [23:0] got_b_q[$];

  gated_pulse_counter #(.CNT_W(23), .SYNC_STAGES(2), .DROP_W(8), .STUCK_W(12)) dut_a (
    .clk_12mhz(clk_12mhz), .rst_sync(rst_sync),
    .cnt_in(cnt_d & ~sel), .cnt_en(en_d), .gate(gate_d & ~sel),
    .count_mode(count_mode), .fifo_full(fifo_full),
    .count_word(word_a), .wr_en(wr_a), .overflow(ovf_a), .drop_cnt(drop_a),
    .busy(busy_a), .state_dbg(st_a)
  );

  gated_pulse_counter #(.CNT_W(4), .SYNC_STAGES(2), .DROP_W(8), .STUCK_W(10)) dut_b (
    .clk_12mhz(clk_12mhz), .rst_sync(rst_sync),
    .cnt_in(cnt_d & sel), .cnt_en(en_d), .gate(gate_d & sel),
    .count_mode(count_mode), .fifo_full(fifo_full),
    .count_word(word_b), .wr_en(wr_b), .overflow(ovf_b), .drop_cnt(drop_b),
    .busy(busy_b), .state_dbg(st_b)
  );

  // write monitors
  always @(negedge clk_12mhz) begin
    if (!rst_sync && wr_a) got_a_q.push_back(word_a);
    if (!rst_sync && wr_b) got_b_q.push_back(word_b);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_12mhz);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cnt_d = 1'b1; tick(2);
      cnt_d = 1'b0; tick(2);
    end
  endtask

  task automatic phase(input logic lvl, input int n);
    gate_d = lvl;
    tick(4);
    pulses(n);
    tick(2);
  endtask

  function automatic logic [23:0] head_a();
    return (got_a_q.size() > 0) ? got_a_q[0] : 24'hxxxxxx;
  endfunction

  // scenarios
  task automatic test_reset();
    rst_sync = 1'b1;
    gate_d = 1'b1; tick(1);
    gate_d = 1'b0; tick(1);
    gate_d = 1'b1; tick(1);
    gate_d = 1'b0;
    total++;
    if (word_a !== 24'h0 || wr_a !== 1'b0 || ovf_a !== 1'b0 || drop_a !== 8'h0 ||
        busy_a !== 1'b0 || st_a !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs: word=%h wr=%b ovf=%b drop=%0d busy=%b st=%0d, want all 0",
               word_a, wr_a, ovf_a, drop_a, busy_a, st_a);
    end
    rst_sync = 1'b0;
    tick(4);
    got_a_q.delete();
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_idle_busy: busy=%b want 0", busy_a);
    end
    phase(1'b1, 3);
    total++;
    if (got_a_q.size() != 0 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL first_rise: writes=%0d busy=%b, want writes=0 busy=1", got_a_q.size(), busy_a);
    end
    phase(1'b0, 1);
    phase(1'b1, 0);
    tick(2);
    total++;
    if (got_a_q.size() != 1 || head_a() !== 24'h000003) begin
      bad++;
      $display("FAIL second_rise_word: writes=%0d word=%h, want 1 x 000003", got_a_q.size(), head_a());
    end
    got_a_q.delete();
  endtask

  task automatic test_mode0();
    count_mode = 1'b0;
    pulses(100);
    phase(1'b0, 40);
    phase(1'b1, 0);
    tick(2);
    total++;
    if (got_a_q.size() != 1 || head_a() !== 24'h000064) begin
      bad++;
      $display("FAIL mode0_100_40: writes=%0d word=%h, want 1 x 000064", got_a_q.size(), head_a());
    end
    got_a_q.delete();
    pulses(5);
    phase(1'b0, 2);
    phase(1'b1, 0);
    tick(2);
    total++;
    if (got_a_q.size() != 1 || head_a() !== 24'h000005) begin
      bad++;
      $display("FAIL mode0_restart: writes=%0d word=%h, want 1 x 000005", got_a_q.size(), head_a());
    end
    got_a_q.delete();
  endtask

  task automatic test_mode1();
    count_mode = 1'b1;
    pulses(40);
    phase(1'b0, 100);
    phase(1'b1, 0);
    tick(2);
    total++;
    if (got_a_q.size() != 1 || head_a() !== 24'hFFFFC4) begin
      bad++;
      $display("FAIL mode1_40_100: writes=%0d word=%h, want 1 x FFFFC4", got_a_q.size(), head_a());
    end
    got_a_q.delete();
    pulses(100);
    phase(1'b0, 40);
    phase(1'b1, 0);
    tick(2);
    total++;
    if (got_a_q.size() != 1 || head_a() !== 24'h00003C) begin
      bad++;
      $display("FAIL mode1_100_40: writes=%0d word=%h, want 1 x 00003C", got_a_q.size(), head_a());
    end
    got_a_q.delete();
  endtask

  // Pulses coincident with the falling and the rising gate edge land in the
  // new phase: PLUS 10, MINUS 1+4 -> diff 5; next PLUS 1+2 -> raw 3.
  task automatic test_coincident();
    count_mode = 1'b1;
    pulses(10);
    gate_d = 1'b0; cnt_d = 1'b1; tick(2);
    cnt_d = 1'b0; tick(2);
    pulses(4);
    tick(2);
    gate_d = 1'b1; cnt_d = 1'b1; tick(2);
    cnt_d = 1'b0; tick(4);
    total++;
    if (got_a_q.size() != 1 || head_a() !== 24'h000005) begin
      bad++;
      $display("FAIL coincident_fall: writes=%0d word=%h, want 1 x 000005", got_a_q.size(), head_a());
    end
    got_a_q.delete();
    count_mode = 1'b0;
    pulses(2);
    phase(1'b0, 0);
    phase(1'b1, 0);
    tick(2);
    total++;
    if (got_a_q.size() != 1 || head_a() !== 24'h000003) begin
      bad++;
      $display("FAIL coincident_rise: writes=%0d word=%h, want 1 x 000003", got_a_q.size(), head_a());
    end
    got_a_q.delete();
  endtask

  task automatic test_enable();
    count_mode = 1'b1;
    en_d = 1'b0; tick(4);
    pulses(10);
    en_d = 1'b1; tick(4);
    pulses(7);
    phase(1'b0, 2);
    phase(1'b1, 0);
    tick(2);
    total++;
    if (got_a_q.size() != 1 || head_a() !== 24'h000005) begin
      bad++;
      $display("FAIL cnt_en_gating: writes=%0d word=%h, want 1 x 000005", got_a_q.size(), head_a());
    end
    got_a_q.delete();
  endtask

  task automatic test_fifo_full();
    total++;
    if (ovf_a !== 1'b0 || drop_a !== 8'd0) begin
      bad++;
      $display("FAIL pre_full_flags: ovf=%b drop=%0d, want 0 0", ovf_a, drop_a);
    end
    count_mode = 1'b0;
    fifo_full = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pulses(3);
      phase(1'b0, 1);
      phase(1'b1, 0);
    end
    tick(2);
    total++;
    if (got_a_q.size() != 0) begin
      bad++; $display("FAIL full_no_write: writes=%0d want 0", got_a_q.size());
    end
    total++;
    if (drop_a !== 8'd3 || ovf_a !== 1'b1) begin
      bad++; $display("FAIL full_drops: drop=%0d ovf=%b, want 3 1", drop_a, ovf_a);
    end
    fifo_full = 1'b0;
    pulses(7);
    phase(1'b0, 2);
    phase(1'b1, 0);
    tick(2);
    total++;
    if (got_a_q.size() != 1 || head_a() !== 24'h000007 || drop_a !== 8'd3) begin
      bad++;
      $display("FAIL after_full_word: writes=%0d word=%h drop=%0d, want 1 x 000007 drop 3",
               got_a_q.size(), head_a(), drop_a);
    end
    got_a_q.delete();
  endtask

  task automatic test_saturate_stuck();
    gate_d = 1'b0; tick(4);
    sel = 1'b1; tick(4);
    count_mode = 1'b0;
    got_b_q.delete();
    phase(1'b1, 20);
    phase(1'b0, 0);
    phase(1'b1, 0);
    tick(2);
    total++;
    if (got_b_q.size() != 1 || (got_b_q.size() > 0 && got_b_q[0] !== 24'h80000F)) begin
      bad++;
      $display("FAIL sat_word: writes=%0d word=%h, want 1 x 80000F", got_b_q.size(), word_b);
    end
    total++;
    if (ovf_b !== 1'b1 || busy_b !== 1'b1) begin
      bad++; $display("FAIL sat_flags: ovf=%b busy=%b, want 1 1", ovf_b, busy_b);
    end
    got_b_q.delete();
    phase(1'b0, 0);
    tick(1100);
    total++;
    if (busy_b !== 1'b0 || st_b !== 2'd0 || got_b_q.size() != 0) begin
      bad++;
      $display("FAIL stuck_gate: busy=%b st=%0d writes=%0d, want 0 0 0", busy_b, st_b, got_b_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_coincident();
    test_enable();
    test_fifo_full();
    test_saturate_stuck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
